// File: rtl/shade_scheduler.sv
// shade_scheduler: round-robin arbiter that shares one shading datapath among NUM_REQ cores.
// Optional SHADE_SCHED_PERF_EN adds perf_pixels/perf_stall counters.
module shade_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH = 24,
    parameter int TAG_WIDTH = 19,
    parameter int SHADE_LAT = 0,
    parameter logic [OUT_WIDTH-1:0] BG_COLOR = '0,
    localparam int SW = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_hit,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_nx,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_ny,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_nz,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
    input  logic                            light_load,
    input  logic [DATA_WIDTH-1:0]           light_x,
    input  logic [DATA_WIDTH-1:0]           light_y,
    input  logic [DATA_WIDTH-1:0]           light_z,
    output logic                            light_busy,
    output logic [DATA_WIDTH-1:0]           sh_nx,
    output logic [DATA_WIDTH-1:0]           sh_ny,
    output logic [DATA_WIDTH-1:0]           sh_nz,
    output logic [DATA_WIDTH-1:0]           sh_lx,
    output logic [DATA_WIDTH-1:0]           sh_ly,
    output logic [DATA_WIDTH-1:0]           sh_lz,
    input  logic [OUT_WIDTH-1:0]            sh_shade,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_WIDTH-1:0]            out_pixel,
    output logic [TAG_WIDTH-1:0]            out_tag,
    output logic [SW-1:0]                   out_src
`ifdef SHADE_SCHED_PERF_EN
    ,
    output logic [31:0]                     perf_pixels,
    output logic [31:0]                     perf_stall
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
    state_t state, state_n;
    logic [SW-1:0] rr_ptr, g, idx;
    logic [SW:0] sum;
    logic any;
    logic [3:0] cnt;

    // Descending scan so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        g = rr_ptr;
        any = 1'b0;
        sum = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (SW+1)'(k);
            idx = (sum >= (SW+1)'(NUM_REQ)) ? SW'(sum - (SW+1)'(NUM_REQ)) : SW'(sum);
            if (req_valid[idx]) begin
                g = idx;
                any = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = (state == IDLE) ? (any ? (req_hit[g] ? WAIT : OUT) : IDLE)
                : (state == WAIT) ? ((cnt == 4'(SHADE_LAT)) ? OUT : WAIT)
                : (out_ready ? IDLE : OUT);
        req_ready = (state == IDLE && any) ? NUM_REQ'(1) << g : '0;
    end

    assign out_valid = (state == OUT);
    assign light_busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            out_pixel <= '0;
            out_tag <= '0;
            out_src <= '0;
            sh_nx <= '0;
            sh_ny <= '0;
            sh_nz <= '0;
            sh_lx <= '0;
            sh_ly <= DATA_WIDTH'(32'h01000000);
            sh_lz <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && light_load) begin
                sh_lx <= light_x;
                sh_ly <= light_y;
                sh_lz <= light_z;
            end
            if (state == IDLE && any) begin
                out_tag <= req_tag[g*TAG_WIDTH +: TAG_WIDTH];
                out_src <= g;
                rr_ptr <= (g == SW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                cnt <= '0;
                if (req_hit[g]) begin
                    sh_nx <= req_nx[g*DATA_WIDTH +: DATA_WIDTH];
                    sh_ny <= req_ny[g*DATA_WIDTH +: DATA_WIDTH];
                    sh_nz <= req_nz[g*DATA_WIDTH +: DATA_WIDTH];
                end else
                    out_pixel <= BG_COLOR;
            end
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == 4'(SHADE_LAT))
                    out_pixel <= sh_shade;
            end
        end
    end

`ifdef SHADE_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_pixels <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready)
                perf_pixels <= perf_pixels + 32'd1;
            if (out_valid && !out_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_shade_scheduler.sv
// tb_shade_scheduler: directed + randomized checks of shade_scheduler against a transaction-level model.
module tb_shade_scheduler;
    localparam int N = 4, DW = 32, OW = 24, TW = 19, LAT = 2;
    localparam logic [OW-1:0] BG = 24'h102030;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req_valid = '0, req_hit = '0, req_ready;
    logic [N*DW-1:0] req_nx, req_ny, req_nz;
    logic [N*TW-1:0] req_tag;
    logic light_load = 1'b0;
    logic [DW-1:0] light_x = '0, light_y = '0, light_z = '0;
    logic light_busy, out_valid, out_ready = 1'b0;
    logic [DW-1:0] sh_nx, sh_ny, sh_nz, sh_lx, sh_ly, sh_lz;
    logic [OW-1:0] sh_shade, out_pixel;
    logic [TW-1:0] out_tag;
    logic [1:0] out_src;
`ifdef SHADE_SCHED_PERF_EN
    logic [31:0] perf_pixels, perf_stall;
`endif

    logic [DW-1:0] nx[N], ny[N], nz[N];
    logic [TW-1:0] tg[N];
    int checks = 0, failures = 0;
    int cyc = 0, gcyc = 0;

    int m_ptr, m_src;
    logic [DW-1:0] m_nx, m_ny, m_nz, m_lx, m_ly, m_lz;
    logic [OW-1:0] m_pix;
    logic [TW-1:0] m_tag;

    shade_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .TAG_WIDTH(TW),
                      .SHADE_LAT(LAT), .BG_COLOR(BG)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_hit(req_hit),
        .req_nx(req_nx), .req_ny(req_ny), .req_nz(req_nz), .req_tag(req_tag),
        .light_load(light_load), .light_x(light_x), .light_y(light_y), .light_z(light_z),
        .light_busy(light_busy), .sh_nx(sh_nx), .sh_ny(sh_ny), .sh_nz(sh_nz),
        .sh_lx(sh_lx), .sh_ly(sh_ly), .sh_lz(sh_lz), .sh_shade(sh_shade),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_tag(out_tag), .out_src(out_src)
`ifdef SHADE_SCHED_PERF_EN
        , .perf_pixels(perf_pixels), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] shade_f(input logic [DW-1:0] a, c, l);
        return a[OW-1:0] ^ c[OW-1:0] ^ l[OW-1:0];
    endfunction

    // The shader only presents a real result in the one cycle the scheduler is allowed to sample it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (|req_ready) gcyc <= cyc;
    end
    assign sh_shade = (cyc == gcyc + 1 + LAT) ? shade_f(sh_nx, sh_nz, sh_lx) : 24'hEE0000 ^ OW'(cyc);

    always_comb begin
        req_nx = '0;
        req_ny = '0;
        req_nz = '0;
        req_tag = '0;
        for (int k = 0; k < N; k++) begin
            req_nx[k*DW +: DW] = nx[k];
            req_ny[k*DW +: DW] = ny[k];
            req_nz[k*DW +: DW] = nz[k];
            req_tag[k*TW +: TW] = tg[k];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_req;
        for (int k = 0; k < N; k++) begin
            nx[k] = $urandom;
            ny[k] = $urandom;
            nz[k] = $urandom;
            tg[k] = TW'($urandom);
        end
    endtask

    task automatic model_reset;
        m_ptr = 0; m_src = 0; m_tag = '0; m_pix = '0;
        m_nx = '0; m_ny = '0; m_nz = '0;
        m_lx = '0; m_ly = 32'h01000000; m_lz = '0;
    endtask

    task automatic check_outs(input string pre);
        chk({pre, "_pix"}, out_pixel, m_pix);
        chk({pre, "_tag"}, out_tag, m_tag);
        chk({pre, "_src"}, out_src, m_src);
        chk({pre, "_nx"}, sh_nx, m_nx);
        chk({pre, "_ny"}, sh_ny, m_ny);
        chk({pre, "_nz"}, sh_nz, m_nz);
        chk({pre, "_lx"}, sh_lx, m_lx);
        chk({pre, "_ly"}, sh_ly, m_ly);
        chk({pre, "_lz"}, sh_lz, m_lz);
    endtask

    // One complete transaction from IDLE: grant, latency, optional back-pressure, handshake.
    task automatic xact(input logic [N-1:0] mask, input logic [N-1:0] hits, input bit ld,
                        input bit wait_ld, input int stall);
        int g, lat, k;
`ifdef SHADE_SCHED_PERF_EN
        logic [31:0] p0;
`endif
        g = -1;
        for (int i = 0; i < N; i++)
            if (g < 0 && mask[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        req_valid = mask;
        req_hit = hits;
        light_load = ld;
        #2;
        chk("grant", req_ready, N'(1) << g);
        chk("busy_idle", light_busy, 0);
        tick;
        req_valid = '0;
        light_load = wait_ld;
        m_ptr = (g + 1) % N;
        m_src = g;
        m_tag = tg[g];
        if (ld) begin m_lx = light_x; m_ly = light_y; m_lz = light_z; end
        if (hits[g]) begin
            m_nx = nx[g]; m_ny = ny[g]; m_nz = nz[g];
            m_pix = shade_f(m_nx, m_nz, m_lx);
            lat = LAT + 2;
        end else begin
            m_pix = BG;
            lat = 1;
        end
        k = 1;
        while (!out_valid && k < 20) begin
            chk("busy_wait", light_busy, 1);
            tick;
            light_load = 1'b0;
            k++;
        end
        chk("latency", k, lat);
        check_outs("out");
`ifdef SHADE_SCHED_PERF_EN
        p0 = perf_stall;
`endif
        for (int s = 0; s < stall; s++) begin
            req_valid = N'($urandom);
            tick;
            light_load = 1'b0;
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_pix", out_pixel, m_pix);
            chk("bp_tag", out_tag, m_tag);
            chk("bp_src", out_src, m_src);
        end
`ifdef SHADE_SCHED_PERF_EN
        chk("perf_stall", perf_stall - p0, stall);
`endif
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        req_valid = '0;
        light_load = 1'b0;
        #1;
        chk("drained", out_valid, 0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin nx[k] = '0; ny[k] = '0; nz[k] = '0; tg[k] = '0; end
        model_reset();
        tick;
        tick;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", light_busy, 0);
        check_outs("rst");
        rst = 1'b0;
        tick;

        // Fairness: all cores request hits continuously.
        for (int i = 0; i < 5; i++) begin
            rand_req();
            xact(4'hF, 4'hF, 1'b0, 1'b0, 0);
            chk("rr_order", out_src, i % N);
        end

        // Single hit on core 2 with a known shader result.
        rand_req();
        nx[2] = 32'h00A1B2C3;
        nz[2] = '0;
        tg[2] = 19'd5;
        xact(4'b0100, 4'b0100, 1'b0, 1'b0, 0);
        chk("single_pix", m_pix, 24'hA1B2C3);

        // Miss on core 1: background colour, normals untouched.
        rand_req();
        xact(4'b0010, 4'b0000, 1'b0, 1'b0, 0);

        // Back-pressure for 10 cycles.
        rand_req();
        xact(4'b1000, 4'b1000, 1'b0, 1'b0, 10);

        // Randomized traffic with light loads and stalls.
        for (int i = 0; i < 40; i++) begin
            rand_req();
            light_x = $urandom;
            light_y = $urandom;
            light_z = $urandom;
            xact(N'($urandom_range(1, 15)), N'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3));
        end

        // Light gating: load in IDLE, ignored pulse in WAIT, then load in IDLE again.
        light_x = 32'd1; light_y = 32'd2; light_z = 32'd3;
        light_load = 1'b1;
        tick;
        light_load = 1'b0;
        m_lx = 32'd1; m_ly = 32'd2; m_lz = 32'd3;
        chk("ld_lx", sh_lx, m_lx);
        chk("ld_lz", sh_lz, m_lz);
        light_x = '0; light_y = '0; light_z = 32'h01000000;
        rand_req();
        xact(4'b0001, 4'b0001, 1'b0, 1'b1, 0);
        light_load = 1'b1;
        tick;
        light_load = 1'b0;
        chk("ld2_lz", sh_lz, 32'h01000000);
        chk("ld2_lx", sh_lx, 0);
        m_lx = '0; m_ly = '0; m_lz = 32'h01000000;

        // Asynchronous reset during WAIT.
        rand_req();
        req_valid = 4'b0001;
        req_hit = 4'b0001;
        #2;
        chk("pre_rst_grant", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        tick;
        chk("pre_rst_busy", light_busy, 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_ready", req_ready, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", light_busy, 0);
        check_outs("arst");
        tick;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("no_stale", out_valid, 0);
        end
        rand_req();
        xact(4'hF, 4'hF, 1'b0, 1'b0, 0);
        chk("post_rst_src", out_src, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shade_scheduler.md
# shade_scheduler

Round-robin controller that shares one shading datapath between `NUM_REQ` ray-march cores. Each core hands over a surface normal (or a miss) with a pixel tag. The scheduler arbitrates among the cores, drives the shader with that normal and the current light vector, and waits the shader's fixed latency. It then returns a packed RGB888 pixel with its tag on a valid/ready stream toward the framebuffer writer.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting cores, 2..8.
- `DATA_WIDTH`, 32: Q8.24 operand width.
- `OUT_WIDTH`, 24: packed pixel width {R,G,B}.
- `TAG_WIDTH`, 19: pixel index width.
- `SHADE_LAT`, 0: shader latency in cycles, 0..15.
- `BG_COLOR`, 24'h000000: pixel emitted on a miss.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: asynchronous active-high reset.
- `req_valid`, in, NUM_REQ: per-core request.
- `req_ready`, out, NUM_REQ: one-hot grant/accept.
- `req_hit`, in, NUM_REQ: 1 = surface hit, 0 = miss.
- `req_nx`, `req_ny`, `req_nz`, in, NUM_REQ*DATA_WIDTH each: flattened Q8.24 normals; core i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_tag`, in, NUM_REQ*TAG_WIDTH: flattened pixel index.
- `light_load`, in, 1: load the light vector.
- `light_x`, `light_y`, `light_z`, in, DATA_WIDTH each: Q8.24 light vector.
- `light_busy`, out, 1: high whenever state ≠ IDLE.
- `sh_nx`, `sh_ny`, `sh_nz`, `sh_lx`, `sh_ly`, `sh_lz`, out, DATA_WIDTH each: shader operands, all registered.
- `sh_shade`, in, OUT_WIDTH: shader result.
- `out_valid`, out, 1: pixel available.
- `out_ready`, in, 1: downstream accept.
- `out_pixel`, out, OUT_WIDTH: RGB888 result.
- `out_tag`, out, TAG_WIDTH: pixel index.
- `out_src`, out, clog2(NUM_REQ): index of the granted core.

## Operation
- The FSM has three states: IDLE, WAIT and OUT.
- **IDLE**:
  - If any `req_valid` is set, grant the first set bit at or after pointer `rr_ptr`, searching cyclically.
  - `req_ready[g]=1` in the same cycle. It is combinational from `req_valid` and `rr_ptr`, and zero in every other state.
  - On grant, latch `req_tag[g]` and `g`, set `rr_ptr = (g+1) mod NUM_REQ`.
  - Hit: latch the normal into `sh_n*` and go to WAIT with `cnt=0`.
  - Miss: load `out_pixel=BG_COLOR` and go to OUT. The shader is not touched and `sh_n*` holds its previous value.
  - With no request, stay in IDLE.
- **WAIT**:
  - If `cnt==SHADE_LAT`, capture `sh_shade` into `out_pixel` and go to OUT.
  - Otherwise increment `cnt`.
- **OUT**:
  - `out_valid=1`. `out_pixel`, `out_tag` and `out_src` are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- **Light update**:
  - `light_load` is honoured only in IDLE, and takes priority alongside a grant: both happen in the same cycle, and the granted pixel uses the new vector.
  - `light_load` outside IDLE is ignored. Software polls `light_busy`.
- The normal and light vectors pass through unmodified; the scheduler does no arithmetic on them. The shader is responsible for clamping.
- A core must hold its request fields stable while `req_valid` is high and `req_ready` is low.

## Timing
- Reset values:
  - `rr_ptr=0`, state IDLE.
  - `req_ready=0`, `out_valid=0`, `out_pixel=0`, `out_tag=0`, `out_src=0`, `light_busy=0`.
  - `sh_nx=sh_ny=sh_nz=0`.
  - `sh_lx=0`, `sh_ly=32'h01000000`, `sh_lz=0`.
- Grant on a hit in cycle T:
  - `sh_n*` is valid from T+1.
  - `sh_shade` is sampled at the end of T+1+SHADE_LAT.
  - `out_valid` is high from T+2+SHADE_LAT.
- Grant on a miss in cycle T: `out_valid` is high from T+1.
- Output accepted in cycle U: the state is IDLE at U+1, and the earliest next grant is U+1.
- Peak throughput is one hit per SHADE_LAT+3 cycles and one miss per 2 cycles.
- Back-pressure: while `out_ready` is low in OUT, no grants are made and the outputs stay stable.
- Asserting `rst` mid-operation asynchronously returns everything to its reset values; any in-flight pixel is dropped and not emitted.

## Configuration
- `SHADE_SCHED_PERF_EN`:
  - Defined: adds two outputs, `perf_pixels` (32-bit, increments on each output handshake) and `perf_stall` (32-bit, increments each cycle with `out_valid && !out_ready`).
  - Both counters reset to 0, wrap at 2^32, and are not gated by `light_load`.
  - Undefined: the ports and counters are absent. Functional behaviour is identical in both builds.

## Test plan
- **Single hit**: NUM_REQ=4, SHADE_LAT=2; core 2 sends a hit with tag 5; the shader model returns 24'hA1B2C3. Required: `out_valid` at grant+4 with `out_pixel=A1B2C3`, `out_tag=5`, `out_src=2`.
- **Round-robin fairness**: all four cores hold `req_valid` with hits, `out_ready=1`. Required: grant order 0,1,2,3,0.
- **Miss path**: core 1 sends a miss with BG_COLOR=24'h102030. Required: `out_valid` at grant+1 with `out_pixel=102030`; `sh_n*` unchanged.
- **Back-pressure**: hold `out_ready=0` for 10 cycles in OUT. Required:
  - `out_*` stable throughout.
  - `req_ready` all zero.
  - With the macro defined, `perf_stall` increases by 10.
- **Light gating**: pulse `light_load` during WAIT with (0, 0, 32'h01000000), then again in IDLE. Required: the first pulse is ignored; after the second, `sh_lz=32'h01000000`.
- **Reset mid-operation**: assert `rst` during WAIT. Required: all outputs at reset values immediately; the next grant goes to core 0 and no stale pixel appears.
